// File: rtl/cd_xfer_fifo.sv
// cd_xfer_fifo: parametrised CD <-> host data-transfer FIFO with hysteretic
// DREQ generation and a bounded A-bus wait state machine.
// Optional feature macro: CD_XFER_FIFO_STAT_EN (sticky OVF/UDF/TMO flags);
// when undefined the flags are tied to 0.
module cd_xfer_fifo #(
    parameter int unsigned DW       = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned LWM      = 2,
    parameter int unsigned HWM      = DEPTH - 2,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     FLUSH,
    input  logic                     EN,
    input  logic                     DIR,
    input  logic                     WR_STB,
    input  logic [DW-1:0]            WR_DATA,
    input  logic                     RD_STB,
    output logic [DW-1:0]            RD_DATA,
    input  logic                     ABUS_RD,
    input  logic                     WAIT_REL,
    output logic                     AWAIT_N,
    output logic                     DREQ,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic                     OVF,
    output logic                     UDF,
    output logic                     TMO
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = 16;

    typedef enum logic {ST_IDLE, ST_HOLD} state_t;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [LW-1:0] level_q, level_d;
    logic          empty_q, empty_d, full_q, full_d;
    logic          dreq_q, dreq_d;
    logic          dir_q, dir_d;
    logic          abus_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          dir_eff_c;
    logic          wr_acc_c;
    logic          pop_c;
    logic          hold_release_c;
    logic          timeout_c;

    // Direction follows DIR only while empty; otherwise the latched value holds
    assign dir_eff_c      = empty_q ? DIR : dir_q;
    assign wr_acc_c       = WR_STB & EN & (~full_q | RD_STB);
    assign pop_c          = RD_STB & ~empty_q;
    assign hold_release_c = ~empty_q | WAIT_REL | ~ABUS_RD | dir_eff_c;
    assign timeout_c      = (cnt_q == CW'(WAIT_MAX - 1));

    assign RD_DATA = mem_q[rp_q];
    assign LEVEL   = level_q;
    assign EMPTY   = empty_q;
    assign FULL    = full_q;
    assign DREQ    = dreq_q;
    assign AWAIT_N = (state_q != ST_HOLD);

    // Next-state: storage, pointers, level, DREQ hysteresis and wait FSM
    always_comb begin
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        level_d = level_q;
        dreq_d  = dreq_q;
        dir_d   = dir_eff_c;
        state_d = state_q;
        cnt_d   = cnt_q;

        if (FLUSH) begin
            wp_d    = '0;
            rp_d    = '0;
            level_d = '0;
            dreq_d  = 1'b0;
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            if (wr_acc_c) begin
                mem_d[wp_q] = WR_DATA;
                wp_d        = wp_q + AW'(1);
            end
            if (pop_c) begin
                rp_d = rp_q + AW'(1);
            end
            if (wr_acc_c && !pop_c) begin
                level_d = level_q + LW'(1);
            end else if (!wr_acc_c && pop_c) begin
                level_d = level_q - LW'(1);
            end

            // DREQ: set/clear thresholds mirror around DEPTH when host produces
            if (!EN) begin
                dreq_d = 1'b0;
            end else if (!dir_eff_c) begin
                if (level_q <= LW'(LWM)) begin
                    dreq_d = 1'b1;
                end else if (level_q >= LW'(HWM)) begin
                    dreq_d = 1'b0;
                end
            end else begin
                if (level_q >= LW'(DEPTH - LWM)) begin
                    dreq_d = 1'b1;
                end else if (level_q <= LW'(DEPTH - HWM)) begin
                    dreq_d = 1'b0;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (ABUS_RD && !abus_q && !dir_eff_c && empty_q) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end
                end
                ST_HOLD: begin
                    if (hold_release_c || timeout_c) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        empty_d = (level_d == '0);
        full_d  = (level_d == LW'(DEPTH));
    end

    // State registers; memory resets to zero so RD_DATA is defined after reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            dreq_q  <= 1'b0;
            dir_q   <= 1'b0;
            abus_q  <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            mem_q   <= mem_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            level_q <= level_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            dreq_q  <= dreq_d;
            dir_q   <= dir_d;
            abus_q  <= ABUS_RD;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef CD_XFER_FIFO_STAT_EN
    logic ovf_q, ovf_d, udf_q, udf_d, tmo_q, tmo_d;

    // Sticky error flags, cleared only by FLUSH or reset
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        tmo_d = tmo_q;
        if (FLUSH) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
            tmo_d = 1'b0;
        end else begin
            if (WR_STB && EN && full_q && !RD_STB) begin
                ovf_d = 1'b1;
            end
            if (RD_STB && empty_q) begin
                udf_d = 1'b1;
            end
            if (state_q == ST_HOLD && !hold_release_c && timeout_c) begin
                tmo_d = 1'b1;
            end
        end
    end

    // Sticky flag registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
            tmo_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
            tmo_q <= tmo_d;
        end
    end

    assign OVF = ovf_q;
    assign UDF = udf_q;
    assign TMO = tmo_q;
`else
    assign OVF = 1'b0;
    assign UDF = 1'b0;
    assign TMO = 1'b0;
`endif

endmodule

// File: tb/tb_cd_xfer_fifo.sv
// Scoreboard bench for cd_xfer_fifo: a queue-based reference model predicts
// the registered outputs after each clock; a monitor compares them.
module tb_cd_xfer_fifo;

    localparam int DW       = 16;
    localparam int DEPTH    = 8;
    localparam int LWM      = 2;
    localparam int HWM      = 6;
    localparam int WAIT_MAX = 16;
`ifdef CD_XFER_FIFO_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          FLUSH = 1'b0, EN = 1'b0, DIR = 1'b0;
    logic          WR_STB = 1'b0, RD_STB = 1'b0;
    logic [DW-1:0] WR_DATA = '0;
    logic [DW-1:0] RD_DATA;
    logic          ABUS_RD = 1'b0, WAIT_REL = 1'b0;
    logic          AWAIT_N, DREQ, EMPTY, FULL, OVF, UDF, TMO;
    logic [$clog2(DEPTH):0] LEVEL;

    cd_xfer_fifo #(
        .DW(DW), .DEPTH(DEPTH), .LWM(LWM), .HWM(HWM), .WAIT_MAX(WAIT_MAX)
    ) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .EN(EN), .DIR(DIR),
        .WR_STB(WR_STB), .WR_DATA(WR_DATA), .RD_STB(RD_STB), .RD_DATA(RD_DATA),
        .ABUS_RD(ABUS_RD), .WAIT_REL(WAIT_REL), .AWAIT_N(AWAIT_N), .DREQ(DREQ),
        .LEVEL(LEVEL), .EMPTY(EMPTY), .FULL(FULL), .OVF(OVF), .UDF(UDF), .TMO(TMO)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          level;
        bit          empty, full, dreq, awaitn, ovf, udf, tmo, hv;
        logic [15:0] head;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;

    // Reference model state
    logic [15:0] m_q[$];
    bit          m_dir, m_dreq, m_ovf, m_udf, m_tmo, m_hold, m_abus_prev;
    int          m_low_cycles;

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h) at %0t",
                     name, act, act, req, req, $time);
        end
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_dir = 0; m_dreq = 0; m_ovf = 0; m_udf = 0; m_tmo = 0;
        m_hold = 0; m_abus_prev = 0; m_low_cycles = 0;
    endfunction

    // One clock of the behavioural model, then queue the predicted outputs
    function automatic void model_step(bit fl, bit en, bit dr, bit wr, logic [15:0] wd,
                                       bit rd, bit ab, bit wrl);
        int  sz   = m_q.size();
        bit  deff = (sz == 0) ? dr : m_dir;
        exp_t e;
        m_dir = deff;
        if (fl) begin
            m_q.delete();
            m_ovf = 0; m_udf = 0; m_tmo = 0; m_dreq = 0; m_hold = 0;
        end else begin
            bit do_pop = rd && sz > 0;
            bit do_wr  = wr && en && (sz < DEPTH || rd);
            if (wr && en && sz == DEPTH && !rd) m_ovf = 1;
            if (rd && sz == 0) m_udf = 1;
            if (!en) m_dreq = 0;
            else if (!deff) begin
                if (sz <= LWM) m_dreq = 1; else if (sz >= HWM) m_dreq = 0;
            end else begin
                if (sz >= DEPTH - LWM) m_dreq = 1; else if (sz <= DEPTH - HWM) m_dreq = 0;
            end
            if (m_hold) begin
                if (sz != 0 || wrl || !ab || deff) m_hold = 0;
                else if (m_low_cycles == WAIT_MAX) begin m_hold = 0; m_tmo = 1; end
                else m_low_cycles++;
            end else if (ab && !m_abus_prev && !deff && sz == 0) begin
                m_hold = 1; m_low_cycles = 1;
            end
            if (do_pop) void'(m_q.pop_front());
            if (do_wr) m_q.push_back(wd);
        end
        m_abus_prev = ab;
        e.level  = m_q.size();
        e.empty  = (m_q.size() == 0);
        e.full   = (m_q.size() == DEPTH);
        e.dreq   = m_dreq;
        e.awaitn = !m_hold;
        e.ovf    = STAT & m_ovf;
        e.udf    = STAT & m_udf;
        e.tmo    = STAT & m_tmo;
        e.hv     = (m_q.size() != 0);
        e.head   = e.hv ? m_q[0] : 16'h0;
        exp_q.push_back(e);
    endfunction

    task automatic cyc(input bit fl, input bit en, input bit dr, input bit wr,
                       input logic [15:0] wd, input bit rd, input bit ab, input bit wrl);
        @(negedge CLK);
        RST = 0; FLUSH = fl; EN = en; DIR = dr; WR_STB = wr; WR_DATA = wd;
        RD_STB = rd; ABUS_RD = ab; WAIT_REL = wrl;
        model_step(fl, en, dr, wr, wd, rd, ab, wrl);
    endtask

    // Assert reset asynchronously and check reset values immediately
    task automatic do_reset();
        @(negedge CLK);
        RST = 1; FLUSH = 0; EN = 0; DIR = 0; WR_STB = 0; RD_STB = 0;
        ABUS_RD = 0; WAIT_REL = 0;
        #1;
        chk("rst_level", int'(LEVEL), 0);
        chk("rst_empty", int'(EMPTY), 1);
        chk("rst_full", int'(FULL), 0);
        chk("rst_dreq", int'(DREQ), 0);
        chk("rst_awaitn", int'(AWAIT_N), 1);
        chk("rst_ovf", int'(OVF), 0);
        chk("rst_udf", int'(UDF), 0);
        chk("rst_tmo", int'(TMO), 0);
        chk("rst_rd_data", int'(RD_DATA), 0);
        model_reset();
    endtask

    // Monitor: compare DUT outputs against queued predictions after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("level", int'(LEVEL), e.level);
                chk("empty", int'(EMPTY), int'(e.empty));
                chk("full", int'(FULL), int'(e.full));
                chk("dreq", int'(DREQ), int'(e.dreq));
                chk("await_n", int'(AWAIT_N), int'(e.awaitn));
                chk("ovf", int'(OVF), int'(e.ovf));
                chk("udf", int'(UDF), int'(e.udf));
                chk("tmo", int'(TMO), int'(e.tmo));
                if (e.hv) chk("rd_data", int'(RD_DATA), int'(e.head));
            end
        end
    end

    initial begin
        bit dr_r, ab_r;
        model_reset();
        repeat (2) @(negedge CLK);
        do_reset();

        // Fill 8 words, overflow attempt, write+pop at full, drain
        for (int k = 1; k <= 8; k++) cyc(0, 1, 0, 1, 16'(16'h1111 * k), 0, 0, 0);
        cyc(0, 1, 0, 1, 16'hDEAD, 0, 0, 0);
        cyc(0, 1, 0, 1, 16'h9999, 1, 0, 0);
        for (int k = 0; k < 9; k++) cyc(0, 1, 0, 0, 16'h0, 1, 0, 0);

        // Wait released by data arriving five cycles after ABUS_RD rises
        cyc(0, 1, 0, 0, 16'h0, 0, 0, 0);
        for (int k = 0; k < 5; k++) cyc(0, 1, 0, 0, 16'h0, 0, 1, 0);
        cyc(0, 1, 0, 1, 16'hA5A5, 0, 1, 0);
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 16'h0, 0, 1, 0);
        cyc(0, 1, 0, 0, 16'h0, 1, 0, 0);

        // Timeout with no data, then forced release
        cyc(0, 1, 0, 0, 16'h0, 0, 0, 0);
        for (int k = 0; k < 22; k++) cyc(0, 1, 0, 0, 16'h0, 0, 1, 0);
        cyc(0, 1, 0, 0, 16'h0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cyc(0, 1, 0, 0, 16'h0, 0, 1, 0);
        cyc(0, 1, 0, 0, 16'h0, 0, 1, 1);
        cyc(0, 1, 0, 0, 16'h0, 0, 1, 0);
        cyc(0, 1, 0, 0, 16'h0, 0, 0, 0);

        // Flush at LEVEL=5 with overflow flagged
        for (int k = 0; k < 9; k++) cyc(0, 1, 0, 1, 16'($urandom), 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 16'h0, 1, 0, 0);
        cyc(1, 1, 0, 0, 16'h0, 0, 0, 0);
        cyc(0, 1, 0, 0, 16'h0, 0, 0, 0);

        // DIR change while non-empty is held off until empty
        cyc(0, 1, 0, 1, 16'h1234, 0, 0, 0);
        cyc(0, 1, 0, 1, 16'h5678, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 1, 1, 0, 16'h0, 0, 0, 0);
        cyc(0, 1, 1, 0, 16'h0, 1, 0, 0);
        cyc(0, 1, 1, 0, 16'h0, 1, 0, 0);
        for (int k = 0; k < 8; k++) cyc(0, 1, 1, 1, 16'($urandom), 0, 1, 0);
        for (int k = 0; k < 8; k++) cyc(0, 1, 1, 0, 16'h0, 1, 0, 0);

        // Randomised traffic with phase-biased fill/drain and occasional reset
        dr_r = 0; ab_r = 0;
        for (int i = 0; i < 3000; i++) begin
            bit fill = ((i / 150) % 2) == 0;
            bit wr   = ($urandom_range(0, 99) < (fill ? 70 : 30));
            bit rd   = ($urandom_range(0, 99) < (fill ? 30 : 70));
            if ($urandom_range(0, 19) == 0) dr_r = ~dr_r;
            if ($urandom_range(0, 9) == 0) ab_r = ~ab_r;
            if (i % 700 == 699) do_reset();
            cyc($urandom_range(0, 79) == 0, $urandom_range(0, 15) != 0, dr_r, wr,
                16'($urandom), rd, ab_r, $urandom_range(0, 39) == 0);
        end

        repeat (3) @(negedge CLK);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
